// File: rtl/score_keeper_if.sv
// Frame-rate bus between the ball block, the score keeper and its consumers.
// The master drives BallX/new_game; the slave (score_keeper) returns the game state.
interface score_keeper_if;
    logic [9:0] BallX;
    logic       new_game;
    logic [3:0] Score1;
    logic [3:0] Score2;
    logic       goal_pulse;
    logic       serve_hold;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output BallX, new_game,
        input  Score1, Score2, goal_pulse, serve_hold, game_over, winner
    );

    modport slave (
        input  BallX, new_game,
        output Score1, Score2, goal_pulse, serve_hold, game_over, winner
    );
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: spots goals from consecutive BallX samples, keeps both scores,
// holds the serve after each goal and detects the end of the game.
module score_keeper #(
    parameter int CENTER_X    = 320,
    parameter int EDGE_L      = 16,
    parameter int EDGE_R      = 623,
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    score_keeper_if.slave      bus
);
    localparam logic [9:0] LP_CX   = 10'(CENTER_X);
    localparam logic [9:0] LP_EL   = 10'(EDGE_L);
    localparam logic [9:0] LP_ER   = 10'(EDGE_R);
    localparam logic [3:0] LP_WIN  = 4'(WIN_SCORE);
    localparam logic [7:0] LP_HOLD = 8'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {S_PLAY, S_HOLD, S_OVER} state_t;

    state_t     r_state;
    logic [9:0] r_prev_x;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_score1;
    logic [3:0] r_score2;
    logic       r_goal_pulse;
    logic       r_serve_hold;
    logic       r_game_over;
    logic [1:0] r_winner;

    logic       w_goal_l;
    logic       w_goal_r;
    logic [3:0] w_cur_score;
    logic [3:0] w_new_score;

    // A goal is the ball block recentring the ball right after it sat in an edge zone.
    assign w_goal_l = (r_prev_x <= LP_EL) && (bus.BallX == LP_CX);
    assign w_goal_r = (r_prev_x >= LP_ER) && (bus.BallX == LP_CX);

    // Left-edge exit scores for player 2; saturating increment of the scorer's count.
    assign w_cur_score = w_goal_l ? r_score2 : r_score1;
    assign w_new_score = (w_cur_score >= LP_WIN) ? LP_WIN : w_cur_score + 4'd1;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_PLAY;
            r_prev_x     <= LP_CX;
            r_hold_cnt   <= 8'd0;
            r_score1     <= 4'd0;
            r_score2     <= 4'd0;
            r_goal_pulse <= 1'b0;
            r_serve_hold <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 2'b00;
        end else begin
            r_prev_x     <= bus.BallX;
            r_goal_pulse <= 1'b0;
            if (bus.new_game) begin
                r_score1     <= 4'd0;
                r_score2     <= 4'd0;
                r_winner     <= 2'b00;
                r_game_over  <= 1'b0;
                r_serve_hold <= 1'b1;
                r_hold_cnt   <= LP_HOLD;
                r_state      <= S_HOLD;
            end else begin
                case (r_state)
                    S_PLAY: begin
                        if (w_goal_l || w_goal_r) begin
                            r_goal_pulse <= 1'b1;
                            r_serve_hold <= 1'b1;
                            if (w_goal_l) r_score2 <= w_new_score;
                            else          r_score1 <= w_new_score;
                            if (w_new_score == LP_WIN) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                                r_winner    <= w_goal_l ? 2'b10 : 2'b01;
                            end else begin
                                r_state    <= S_HOLD;
                                r_hold_cnt <= LP_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == 8'd0) begin
                            r_state      <= S_PLAY;
                            r_serve_hold <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 8'd1;
                        end
                    end
                    S_OVER: begin
                        r_serve_hold <= 1'b1;
                        r_game_over  <= 1'b1;
                    end
                    default: begin
                        r_state      <= S_PLAY;
                        r_serve_hold <= 1'b0;
                        r_game_over  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Score1     = r_score1;
    assign bus.Score2     = r_score2;
    assign bus.goal_pulse = r_goal_pulse;
    assign bus.serve_hold = r_serve_hold;
    assign bus.game_over  = r_game_over;
    assign bus.winner     = r_winner;
endmodule
